// File: rtl/din_syn_pkg.sv
// Shared frame constants and receiver state type for the clk/din/syn control link.
// The pattern generator and the receiver both import this package, so the frame
// length and timing limits stay in one place.
package din_syn_pkg;

  // Data bits per frame; the sync pulse follows the last bit.
  localparam int DS_TOTAL_BITS  = 626;
  // Bit-counter width; 2^DS_CNT_W must exceed DS_TOTAL_BITS+1.
  localparam int DS_CNT_W       = 10;
  // clk_in cycles without a ser_clk rise before a partial frame is dropped.
  localparam int DS_TIMEOUT_CYC = 4096;
  // Synchroniser depth on each link line.
  localparam int DS_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/din_syn_rx_if.sv
// Link and result bundle for din_syn_rx.
//   master : the side driving the serial link (pattern generator or bench);
//            drives ser_clk/ser_din/ser_syn/enable, observes the results.
//   slave  : the receiver; samples the link, drives the captured word and status.
interface din_syn_rx_if
  import din_syn_pkg::*;
#(
  parameter int TOTAL_BITS = DS_TOTAL_BITS,
  parameter int CNT_W      = DS_CNT_W
);

  logic                  ser_clk;
  logic                  ser_din;
  logic                  ser_syn;
  logic                  enable;
  logic [TOTAL_BITS-1:0] data_out;
  logic                  frame_valid;
  logic                  length_err;
  logic                  timeout_err;
  logic                  busy;
  logic [CNT_W-1:0]      bit_cnt;
  logic [7:0]            frame_cnt;

  modport master (
    output ser_clk, ser_din, ser_syn, enable,
    input  data_out, frame_valid, length_err, timeout_err, busy, bit_cnt, frame_cnt
  );

  modport slave (
    input  ser_clk, ser_din, ser_syn, enable,
    output data_out, frame_valid, length_err, timeout_err, busy, bit_cnt, frame_cnt
  );

endinterface

// File: rtl/din_syn_sync_edge.sv
// Brings ser_clk, ser_din and ser_syn into the clk_in domain through equal-depth
// synchroniser chains (so the three lines stay aligned) and detects rising edges
// of the synchronised ser_clk.
// Ports:
//   clk_in, rst_n          system clock, async active-low reset
//   ser_clk/ser_din/ser_syn raw link lines
//   strike_s               one-cycle high on a synchronised ser_clk rise
//   din_s, syn_s           synchronised data/sync, aligned with strike_s
module din_syn_sync_edge
  import din_syn_pkg::*;
#(
  parameter int SYNC_STAGES = DS_SYNC_STAGES
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic ser_clk,
  input  logic ser_din,
  input  logic ser_syn,
  output logic strike_s,
  output logic din_s,
  output logic syn_s
);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] din_sync_r;
  logic [SYNC_STAGES-1:0] syn_sync_r;
  logic                   clk_prev_r;

  // Synchroniser chains plus the previous synchronised ser_clk level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r <= '0;
      din_sync_r <= '0;
      syn_sync_r <= '0;
      clk_prev_r <= 1'b0;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ser_clk};
      din_sync_r <= {din_sync_r[SYNC_STAGES-2:0], ser_din};
      syn_sync_r <= {syn_sync_r[SYNC_STAGES-2:0], ser_syn};
      clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
    end
  end

  // Edge detect is an AND of two flops in this domain, so it is glitch-free.
  assign strike_s = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
  assign din_s    = din_sync_r[SYNC_STAGES-1];
  assign syn_s    = syn_sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/din_syn_rx.sv
// Receive end of the clk/din/syn serial control link. Deserialises one frame of
// TOTAL_BITS bits, checks its length on the sync strike and publishes good frames.
// Ports:
//   clk_in  system clock (>= 8x ser_clk)
//   rst_n   async active-low reset
//   bus     din_syn_rx_if.slave: link lines + enable in; data_out, frame_valid,
//           length_err, timeout_err, busy, bit_cnt, frame_cnt out (all registered)
module din_syn_rx
  import din_syn_pkg::*;
#(
  parameter int TOTAL_BITS  = DS_TOTAL_BITS,
  parameter int CNT_W       = DS_CNT_W,
  parameter int TIMEOUT_CYC = DS_TIMEOUT_CYC,
  parameter int SYNC_STAGES = DS_SYNC_STAGES
) (
  input  logic        clk_in,
  input  logic        rst_n,
  din_syn_rx_if.slave bus
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(TOTAL_BITS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  rx_state_e             state_r;
  logic [TOTAL_BITS-1:0] shift_r;
  logic [TOTAL_BITS-1:0] data_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [IDLE_W-1:0]     idle_cnt_r;
  logic                  overflow_r;
  logic                  frame_valid_r;
  logic                  length_err_r;
  logic                  timeout_err_r;
  logic                  busy_r;
  logic [7:0]            frame_cnt_r;

  logic                  strike_s;
  logic                  din_s;
  logic                  syn_s;
  logic [TOTAL_BITS-1:0] shift_in_s;

  din_syn_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .ser_clk  (bus.ser_clk),
    .ser_din  (bus.ser_din),
    .ser_syn  (bus.ser_syn),
    .strike_s (strike_s),
    .din_s    (din_s),
    .syn_s    (syn_s)
  );

  // Right shift with the new bit at the MSB: after TOTAL_BITS shifts the first
  // bit received has walked down to index 0.
  assign shift_in_s = {din_s, shift_r[TOTAL_BITS-1:1]};

  // Receive FSM with all status outputs registered.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      shift_r       <= '0;
      data_r        <= '0;
      bit_cnt_r     <= '0;
      idle_cnt_r    <= '0;
      overflow_r    <= 1'b0;
      frame_valid_r <= 1'b0;
      length_err_r  <= 1'b0;
      timeout_err_r <= 1'b0;
      busy_r        <= 1'b0;
      frame_cnt_r   <= 8'd0;
    end else begin
      frame_valid_r <= 1'b0;
      length_err_r  <= 1'b0;
      timeout_err_r <= 1'b0;
      if (!bus.enable) begin
        // Disabled: drop any partial frame silently, keep data_out/frame_cnt.
        state_r    <= IDLE;
        bit_cnt_r  <= '0;
        idle_cnt_r <= '0;
        overflow_r <= 1'b0;
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            idle_cnt_r <= '0;
            overflow_r <= 1'b0;
            if (strike_s) begin
              if (syn_s) begin
                // Sync with no data bits is a zero-length frame.
                length_err_r <= 1'b1;
              end else begin
                shift_r   <= shift_in_s;
                bit_cnt_r <= CNT_W'(1);
                busy_r    <= 1'b1;
                state_r   <= SHIFT;
              end
            end
          end
          SHIFT: begin
            if (strike_s) begin
              idle_cnt_r <= '0;
              if (syn_s) begin
                if ((bit_cnt_r == FULL_CNT) && !overflow_r) begin
                  data_r        <= shift_r;
                  frame_valid_r <= 1'b1;
                  frame_cnt_r   <= frame_cnt_r + 8'd1;
                end else begin
                  length_err_r <= 1'b1;
                end
                bit_cnt_r  <= '0;
                overflow_r <= 1'b0;
                busy_r     <= 1'b0;
                state_r    <= IDLE;
              end else if (bit_cnt_r < FULL_CNT) begin
                shift_r   <= shift_in_s;
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end else begin
                // Extra bit beyond the frame: discard, remember for the length check.
                overflow_r <= 1'b1;
              end
            end else if (idle_cnt_r == IDLE_LAST) begin
              timeout_err_r <= 1'b1;
              bit_cnt_r     <= '0;
              idle_cnt_r    <= '0;
              overflow_r    <= 1'b0;
              busy_r        <= 1'b0;
              state_r       <= IDLE;
            end else begin
              idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
            end
          end
          default: begin
            state_r    <= IDLE;
            bit_cnt_r  <= '0;
            idle_cnt_r <= '0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out    = data_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.length_err  = length_err_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.busy        = busy_r;
  assign bus.bit_cnt     = bit_cnt_r;
  assign bus.frame_cnt   = frame_cnt_r;

endmodule
